line_follow_ctrl: RTL and testbench

Line-following decision stage directly downstream of the tracker sensor block. It consumes the registered 3-bit `{left, mid, right}` track pattern, debounces it, and runs a steering state machine. The FSM drives per-wheel speed and direction commands into the motor PWM stage. It also handles the lost-line case with a timed search toward the side the line was last seen, and halts if the search times out.

---
 rtl/line_follow_pkg.sv | 23 ++
 rtl/line_follow_ctrl_pattern_debounce.sv | 47 ++++
 rtl/line_follow_ctrl.sv | 145 ++++++++++++++
 tb/tb_line_follow_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-following controller.
package line_follow_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FORWARD = 3'd1,
        S_LEFT    = 3'd2,
        S_RIGHT   = 3'd3,
        S_SEARCH  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_t;

    localparam logic [2:0] PAT_LOST   = 3'b000;
    localparam logic [2:0] PAT_CENTER = 3'b010;
    localparam logic [2:0] PAT_ALL    = 3'b111;
    localparam logic [2:0] PAT_SPLIT  = 3'b101;

endpackage

// File: rtl/line_follow_ctrl_pattern_debounce.sv
// Sample-and-hold debounce: a pattern reaches filt only after DEBOUNCE
// consecutive identical samples.
module pattern_debounce #(
    parameter int DEBOUNCE = 4,
    parameter int WIDTH    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] filt
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] raw_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             load;

    // Run-length counter of identical samples, saturating at CNT_MAX.
    // filt is loaded on the edge where the count reaches CNT_MAX, so a
    // pattern first seen in raw_q at edge t appears in filt at t+DEBOUNCE-1.
    always_comb begin
        cnt_next = '0;
        if (din == raw_q) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        load = (cnt_next == CNT_MAX);
    end

    // Sample register, run counter and accepted pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_q <= '0;
            cnt   <= '0;
            filt  <= '0;
        end else begin
            raw_q <= din;
            cnt   <= cnt_next;
            if (load) begin
                filt <= raw_q;
            end
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following steering FSM with lost-line search and timeout halt.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | not running (enable low or just out of reset)
//   FORWARD | line centred, both wheels full speed
//   LEFT    | line drifting left, slow the left wheel
//   RIGHT   | line drifting right, slow the right wheel
//   SEARCH  | line lost, spin toward last_side, timed
//   HALT    | search timed out, stopped until enable drops
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int         DEBOUNCE     = 4,
    parameter int         LOST_TIMEOUT = 1_000_000,
    parameter logic [9:0] SPD_FULL     = 10'd900,
    parameter logic [9:0] SPD_TURN     = 10'd500,
    parameter logic [9:0] SPD_SPIN     = 10'd400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] detect_road,
    output logic [9:0] left_speed,
    output logic [9:0] right_speed,
    output logic       left_dir,
    output logic       right_dir,
    output logic [2:0] state
);

    localparam int LW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
    localparam logic [LW-1:0] LOST_MAX = LW'(LOST_TIMEOUT - 1);

    logic [2:0]    filt;
    state_t        state_q, state_n;
    side_t         side_q, side_n;
    logic [LW-1:0] lost_q, lost_n;
    logic [9:0]    ls_n, rs_n;
    logic          ld_n, rd_n;

    pattern_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .WIDTH    (3)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (detect_road),
        .filt  (filt)
    );

    // Next state, remembered side and lost-line counter.
    always_comb begin
        state_n = state_q;
        side_n  = side_q;
        lost_n  = '0;
        if (!enable) begin
            state_n = S_IDLE;
        end else if (state_q == S_HALT) begin
            state_n = S_HALT;
        end else begin
            case (filt)
                PAT_CENTER, PAT_ALL: state_n = S_FORWARD;
                3'b110, 3'b100: begin
                    state_n = S_LEFT;
                    side_n  = SIDE_LEFT;
                end
                3'b011, 3'b001: begin
                    state_n = S_RIGHT;
                    side_n  = SIDE_RIGHT;
                end
                PAT_LOST: begin
                    if (state_q == S_SEARCH) begin
                        if (lost_q == LOST_MAX) begin
                            state_n = S_HALT;
                        end else begin
                            state_n = S_SEARCH;
                            lost_n  = lost_q + 1'b1;
                        end
                    end else begin
                        state_n = S_SEARCH;
                    end
                end
                default: begin
                    // Split pattern: keep steering, but leave IDLE/SEARCH.
                    if (state_q == S_IDLE || state_q == S_SEARCH) begin
                        state_n = S_FORWARD;
                    end
                end
            endcase
        end
    end

    // Wheel commands decoded from the state being entered.
    always_comb begin
        ls_n = '0;
        rs_n = '0;
        ld_n = 1'b1;
        rd_n = 1'b1;
        case (state_n)
            S_FORWARD: begin
                ls_n = SPD_FULL;
                rs_n = SPD_FULL;
            end
            S_LEFT: begin
                ls_n = SPD_TURN;
                rs_n = SPD_FULL;
            end
            S_RIGHT: begin
                ls_n = SPD_FULL;
                rs_n = SPD_TURN;
            end
            S_SEARCH: begin
                ls_n = SPD_SPIN;
                rs_n = SPD_SPIN;
                ld_n = (side_n == SIDE_RIGHT);
                rd_n = (side_n == SIDE_LEFT);
            end
            default: ;
        endcase
    end

    // State, side, lost counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            side_q      <= SIDE_LEFT;
            lost_q      <= '0;
            left_speed  <= '0;
            right_speed <= '0;
            left_dir    <= 1'b1;
            right_dir   <= 1'b1;
        end else begin
            state_q     <= state_n;
            side_q      <= side_n;
            lost_q      <= lost_n;
            left_speed  <= ls_n;
            right_speed <= rs_n;
            left_dir    <= ld_n;
            right_dir   <= rd_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl with DEBOUNCE=4 and LOST_TIMEOUT=16.
module tb_line_follow_ctrl;
    import line_follow_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] detect_road;
    logic [9:0] left_speed, right_speed;
    logic       left_dir, right_dir;
    logic [2:0] state;

    line_follow_ctrl #(
        .DEBOUNCE     (4),
        .LOST_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .detect_road (detect_road),
        .left_speed  (left_speed),
        .right_speed (right_speed),
        .left_dir    (left_dir),
        .right_dir   (right_dir),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         tag;
        logic [2:0] st;
        logic [9:0] ls;
        logic [9:0] rs;
        logic       ld;
        logic       rd;
    } exp_t;

    typedef struct {
        logic       en;
        logic [2:0] road;
        int         n;
        state_t     st;
        side_t      sd;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(int due, int tag, state_t st, side_t sd);
        exp_t e;
        e.due = due;
        e.tag = tag;
        e.st  = st;
        e.ls  = 10'd0;
        e.rs  = 10'd0;
        e.ld  = 1'b1;
        e.rd  = 1'b1;
        case (st)
            S_FORWARD: begin e.ls = 10'd900; e.rs = 10'd900; end
            S_LEFT:    begin e.ls = 10'd500; e.rs = 10'd900; end
            S_RIGHT:   begin e.ls = 10'd900; e.rs = 10'd500; end
            S_SEARCH: begin
                e.ls = 10'd400;
                e.rs = 10'd400;
                if (sd == SIDE_LEFT) begin e.ld = 1'b0; e.rd = 1'b1; end
                else                 begin e.ld = 1'b1; e.rd = 1'b0; end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic compare(input exp_t e);
        total++;
        if (state !== e.st || left_speed !== e.ls || right_speed !== e.rs ||
            left_dir !== e.ld || right_dir !== e.rd) begin
            bad++;
            $display("FAIL step%0d: got state=%0d ls=%0d rs=%0d ld=%0b rd=%0b, want state=%0d ls=%0d rs=%0d ld=%0b rd=%0b",
                     e.tag, state, left_speed, right_speed, left_dir, right_dir,
                     e.st, e.ls, e.rs, e.ld, e.rd);
        end
    endtask

    // One clock edge, then score everything due by now at the falling edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            compare(e);
        end
    endtask

    task automatic apply(input logic en, input logic [2:0] road, input int n,
                         input state_t st, input side_t sd, input int tag);
        enable      = en;
        detect_road = road;
        sb.push_back(mk(cyc + n, tag, st, sd));
        repeat (n) step();
    endtask

    task automatic add(input logic en, input logic [2:0] road, input int n,
                       input state_t st, input side_t sd);
        vec_t v;
        v.en = en; v.road = road; v.n = n; v.st = st; v.sd = sd;
        vecs.push_back(v);
    endtask

    initial begin
        // Expected trajectory: each entry holds inputs for n edges, then
        // the outputs required after the last of those edges.
        add(1, 3'b010, 5,  S_FORWARD, SIDE_LEFT);   // 5th edge after release
        add(1, 3'b110, 2,  S_FORWARD, SIDE_LEFT);   // short glitch
        add(1, 3'b010, 4,  S_FORWARD, SIDE_LEFT);
        add(1, 3'b110, 4,  S_FORWARD, SIDE_LEFT);   // one edge too early
        add(1, 3'b110, 1,  S_LEFT,    SIDE_LEFT);
        add(1, 3'b000, 4,  S_LEFT,    SIDE_LEFT);
        add(1, 3'b000, 1,  S_SEARCH,  SIDE_LEFT);
        add(1, 3'b000, 5,  S_SEARCH,  SIDE_LEFT);
        add(1, 3'b001, 4,  S_SEARCH,  SIDE_LEFT);
        add(1, 3'b001, 1,  S_RIGHT,   SIDE_RIGHT);
        add(1, 3'b000, 4,  S_RIGHT,   SIDE_RIGHT);
        add(1, 3'b000, 1,  S_SEARCH,  SIDE_RIGHT);  // search entry
        add(1, 3'b000, 15, S_SEARCH,  SIDE_RIGHT);  // last search cycle
        add(1, 3'b000, 1,  S_HALT,    SIDE_RIGHT);  // entry + 16
        add(1, 3'b010, 8,  S_HALT,    SIDE_RIGHT);  // sticky
        add(0, 3'b010, 1,  S_IDLE,    SIDE_RIGHT);
        add(1, 3'b010, 1,  S_FORWARD, SIDE_RIGHT);
        add(1, 3'b101, 5,  S_FORWARD, SIDE_RIGHT);  // split holds
        add(0, 3'b101, 1,  S_IDLE,    SIDE_RIGHT);
        add(1, 3'b101, 1,  S_FORWARD, SIDE_RIGHT);  // split from IDLE
        add(1, 3'b000, 5,  S_SEARCH,  SIDE_RIGHT);
        add(1, 3'b101, 5,  S_FORWARD, SIDE_RIGHT);  // split from SEARCH
        add(1, 3'b000, 5,  S_SEARCH,  SIDE_RIGHT);
        add(1, 3'b000, 15, S_SEARCH,  SIDE_RIGHT);
        add(0, 3'b000, 1,  S_IDLE,    SIDE_RIGHT);  // enable beats timeout
        add(1, 3'b000, 1,  S_SEARCH,  SIDE_RIGHT);
        add(1, 3'b000, 15, S_SEARCH,  SIDE_RIGHT);  // counter was cleared
        add(1, 3'b000, 1,  S_HALT,    SIDE_RIGHT);
        add(0, 3'b000, 1,  S_IDLE,    SIDE_RIGHT);

        reset       = 1'b0;
        enable      = 1'b1;
        detect_road = 3'b010;
        repeat (3) @(negedge clk);
        compare(mk(0, 0, S_IDLE, SIDE_LEFT));       // reset values

        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].road, vecs[i].n, vecs[i].st, vecs[i].sd, i + 1);
        end

        // Asynchronous reset in the middle of a search.
        apply(1, 3'b000, 1, S_SEARCH, SIDE_RIGHT, 100);
        repeat (7) step();
        #2 reset = 1'b0;
        #1 compare(mk(cyc, 101, S_IDLE, SIDE_LEFT)); // no edge since assert
        @(negedge clk);
        reset = 1'b1;
        apply(1, 3'b000, 1,  S_SEARCH, SIDE_LEFT, 102); // last_side back to LEFT
        apply(1, 3'b000, 15, S_SEARCH, SIDE_LEFT, 103);
        apply(1, 3'b000, 1,  S_HALT,   SIDE_LEFT, 104);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
